priority_arbiter_fixed: RTL and testbench
=========================================

Name: priority_arbiter_fixed

Overview:
- Fixed-priority arbiter: selects one of NUM_REQ requesters each cycle; lowest index wins (req_i[0] highest priority).
- Grant is a registered one-hot vector plus an encoded index and a valid flag.
- Sits in front of a shared resource (bus or port) whose clients assert level requests.
- No fairness and no grant locking: higher-priority requesters may starve lower ones by design.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..32.
- ID_W, $clog2(NUM_REQ), width of encoded grant index; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  level request per requester; bit i = requester i.
- gnt_o  output  NUM_REQ  registered one-hot grant; all-zero when no grant.
- gnt_id_o  output  ID_W  registered index of granted requester; 0 when gnt_vld_o=0.
- gnt_vld_o  output  1  registered; 1 when gnt_o is non-zero.

Behaviour:
- Reset: synchronous, active-high. At a rising clk edge with reset=1: gnt_o=0, gnt_id_o=0, gnt_vld_o=0. Reset overrides any request.
- Reset deasserted mid-operation: grant state is cleared on the reset edge; arbitration resumes on the first edge with reset=0, from current req_i only. No history is kept.
- Arbitration is combinational on req_i: the winner is the lowest index i with req_i[i]=1.
- Latency: on each rising edge with reset=0, gnt_o <= one-hot(winner), gnt_id_o <= winner, gnt_vld_o <= 1. So the grant appears one cycle after the request is sampled.
- No request (req_i=0): on the next edge gnt_o=0, gnt_id_o=0, gnt_vld_o=0.
- Requests are re-evaluated every cycle; no hold or lock. Dropping a request removes its grant on the next edge.
- Simultaneous requests: only the lowest-index requester is granted. Others stay at 0 regardless of how long they have waited.
- Invariants:
  - gnt_o is always zero or one-hot.
  - gnt_vld_o == |gnt_o.
  - gnt_o[gnt_id_o] == 1 whenever gnt_vld_o=1.
  - gnt_o is a subset of the previous cycle's req_i.
- No X propagation: outputs must be defined from the first edge after reset.
- Priority encoding must be generic in NUM_REQ (loop or parameterised structure), not a hardcoded 4-way case.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req_i=4'b1111 -> gnt_o=0000, gnt_id_o=0, gnt_vld_o=0 throughout; first edge after release -> gnt_o=0001, gnt_id_o=0.
- Single request pulse: req_i=0001 for one cycle, then 0000 -> gnt_o=0001 (id 0, vld 1) one cycle later, then 0000 (vld 0) the next cycle.
- Contention: req_i=0010 for one cycle, then 0110 -> gnt_o=0010 (id 1) in both following cycles; requester 2 never granted while req1 is held.
- Low-priority only: req_i=1000 -> next cycle gnt_o=1000, gnt_id_o=3, gnt_vld_o=1; then req_i=0000 -> gnt_o=0000.
- All requesting: req_i=1111 for 3 cycles -> gnt_o=0001 each cycle. Then drop bit 0 (req_i=1110) -> gnt_o=0010 next cycle.
- Mid-operation reset: with gnt_o=0100 active, assert reset one cycle -> gnt_o=0000 on that edge. Deassert with req_i=0100 still high -> gnt_o=0100 on the following edge.

Source files
------------

// File: rtl/priority_arbiter_fixed.sv
`default_nettype none
// ============================================================================
// Module      : priority_arbiter_fixed
// Description : Fixed-priority arbiter for NUM_REQ level requesters.
//               Requester 0 has the highest priority. The winner is picked
//               combinationally from req_i and registered onto a one-hot
//               grant vector, an encoded index and a valid flag, so a grant
//               appears one cycle after its request is sampled. There is no
//               fairness and no locking: lower-index requesters can starve
//               higher-index ones.
// Ports       : clk       - clock, all state changes on the rising edge
//               reset     - synchronous active-high reset, clears all grants
//               req_i     - level request per requester (bit i = requester i)
//               gnt_o     - registered one-hot grant, zero when idle
//               gnt_id_o  - registered index of the granted requester, zero
//                           when idle
//               gnt_vld_o - registered, high whenever gnt_o is non-zero
// Revision    : 1.0 - initial release
// ============================================================================
module priority_arbiter_fixed #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_W-1:0]     gnt_id_o,
  output logic                gnt_vld_o
);

  logic [NUM_REQ-1:0] gnt_d,    gnt_q;
  logic [ID_W-1:0]    gnt_id_d, gnt_id_q;
  logic               gnt_vld_d, gnt_vld_q;

  // Priority encoder: scan from the top index down so that the last match
  // written, i.e. the lowest set index, is the one that survives.
  always_comb begin
    gnt_d     = '0;
    gnt_id_d  = '0;
    gnt_vld_d = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_id_d  = ID_W'(i);
        gnt_vld_d = 1'b1;
      end
    end
    // One-hot is built from the encoded index, so it can never disagree with
    // gnt_id_d or have more than one bit set.
    if (gnt_vld_d) begin
      gnt_d[gnt_id_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign gnt_vld_o = gnt_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_arbiter_fixed.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_arbiter_fixed
// Description : Self-checking bench for priority_arbiter_fixed. A driver
//               applies directed and random request/reset patterns and pushes
//               the expected registered response into a queue; a monitor
//               pops one entry per rising edge and compares it, together
//               with the structural invariants of the grant outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_arbiter_fixed;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int N_RAND  = 400;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    id;
    logic               vld;
  } exp_t;

  logic               clk;
  logic               reset;
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [ID_W-1:0]    gnt_id_o;
  logic               gnt_vld_o;

  exp_t exp_q[$];
  int   errors;
  int   checks;
  logic prev_rst;
  logic [NUM_REQ-1:0] prev_req;

  priority_arbiter_fixed #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .gnt_vld_o (gnt_vld_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the winner is the lowest set bit, isolated arithmetically
  // with req & -req; its index is log2 of that power of two.
  function automatic exp_t model(input logic rst, input logic [NUM_REQ-1:0] req);
    exp_t e;
    logic [NUM_REQ-1:0] low;
    e.gnt = '0;
    e.id  = '0;
    e.vld = 1'b0;
    if (!rst && req != 0) begin
      low   = req & (~req + 1'b1);
      e.gnt = low;
      e.id  = ID_W'($clog2(low));
      e.vld = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus (set away from the rising edge) and record
  // what the DUT must show after the next rising edge.
  task automatic drive(input logic rst, input logic [NUM_REQ-1:0] req);
    reset = rst;
    req_i = req;
    exp_q.push_back(model(rst, req));
    @(negedge clk);
  endtask

  // Monitor: one expected entry is consumed per rising edge.
  initial begin
    exp_t e;
    prev_rst = 1'b1;
    prev_req = '0;
    forever begin
      @(posedge clk);
      prev_rst = reset;
      prev_req = req_i;
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expectation for edge at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("gnt_o",     32'(gnt_o),     32'(e.gnt));
        check("gnt_id_o",  32'(gnt_id_o),  32'(e.id));
        check("gnt_vld_o", 32'(gnt_vld_o), 32'(e.vld));
        check("inv_vld_eq_or",  32'(gnt_vld_o), 32'(|gnt_o));
        check("inv_onehot0",    32'($onehot0(gnt_o)), 32'(1));
        check("inv_subset_req", 32'(gnt_o & ~(prev_rst ? '0 : prev_req)), 32'(0));
        if (gnt_vld_o) check("inv_id_points", 32'(gnt_o[gnt_id_o]), 32'(1));
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    req_i  = '0;

    // Reset held with all requesting, then release.
    drive(1'b1, 4'b1111);
    drive(1'b1, 4'b1111);
    drive(1'b0, 4'b1111);
    drive(1'b0, 4'b0000);
    // Single pulse.
    drive(1'b0, 4'b0001);
    drive(1'b0, 4'b0000);
    // Contention: requester 1 keeps priority over 2.
    drive(1'b0, 4'b0010);
    drive(1'b0, 4'b0110);
    drive(1'b0, 4'b0110);
    // Lowest priority alone.
    drive(1'b0, 4'b1000);
    drive(1'b0, 4'b0000);
    // All requesting, then drop bit 0.
    drive(1'b0, 4'b1111);
    drive(1'b0, 4'b1111);
    drive(1'b0, 4'b1111);
    drive(1'b0, 4'b1110);
    // Mid-operation reset with requester 2 active.
    drive(1'b0, 4'b0100);
    drive(1'b1, 4'b0100);
    drive(1'b0, 4'b0100);
    drive(1'b0, 4'b0000);

    for (int n = 0; n < N_RAND; n++) begin
      drive(($urandom_range(15) == 0), NUM_REQ'($urandom));
    end

    reset = 1'b0;
    req_i = '0;
    // Let the monitor drain the last expectation; bounded wait.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
